// File: rtl/dfe_coeff_loader.sv
// dfe_coeff_loader
// Loads one DFE filter target's coefficient set. A load command names the
// target. The sequencer then pulls that target's words from a valid/ready
// stream and issues one configuration-bus write per word, at addresses
// 0..last. The target's bypass request is held for the whole load.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start, target           load request (sampled in IDLE), target 0..3
//   abort                   terminate the load in progress
//   coeff_valid/_data/_ready  coefficient stream (signed words)
//   MTRANS, MWRITE, MSELx   bus strobe, write enable, one-hot target select
//   MADDR, MWDATA           coefficient index and word
//   bypass_req              one-hot bypass hold for the target being loaded
//   busy, done, aborted     status: load active, completion pulse, abort pulse
//   words_written           writes issued in the current/last load
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start
// FETCH | coeff_ready high, waiting for a stream word
// WRITE | one bus write cycle for the word just accepted
// DONE  | one-cycle completion pulse
module dfe_coeff_loader #(
  parameter int ADDR_WIDTH  = 7,
  parameter int COEFF_WIDTH = 20,
  parameter int COMP        = 4,
  parameter int N_TAP       = 72,
  parameter int NUM_DENUM   = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             target,
  input  logic                   abort,
  input  logic                   coeff_valid,
  input  logic [COEFF_WIDTH-1:0] coeff_data,
  output logic                   coeff_ready,
  output logic                   MTRANS,
  output logic                   MWRITE,
  output logic [COMP-1:0]        MSELx,
  output logic [ADDR_WIDTH-1:0]  MADDR,
  output logic [COEFF_WIDTH-1:0] MWDATA,
  output logic [COMP-1:0]        bypass_req,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [6:0]             words_written
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_FRAC = ADDR_WIDTH'(N_TAP - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IIR  = ADDR_WIDTH'(NUM_DENUM - 1);

  state_t                 state_q, state_d;
  logic [1:0]             tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  last_q, last_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [COEFF_WIDTH-1:0] wdata_d;
  logic [6:0]             ww_d;
  logic                   aborted_d;
  logic [COMP-1:0]        sel_d;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    addr_d    = MADDR;
    wdata_d   = MWDATA;
    ww_d      = words_written;
    aborted_d = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is meaningless here, so start wins even if both are high
        if (start) begin
          tgt_d   = target;
          last_d  = (target == 2'd0) ? LAST_FRAC : LAST_IIR;
          idx_d   = '0;
          ww_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (coeff_valid && coeff_ready) begin
          addr_d  = idx_q;
          wdata_d = coeff_data;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // the write on the bus this cycle is counted even if it is aborted
        if (words_written != 7'd127) ww_d = words_written + 7'd1;
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (idx_q == last_q) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d   = IDLE;
        aborted_d = abort;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_d = COMP'(1) << tgt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  // Outputs are decoded from the next state so every output is a flop
  // that already reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coeff_ready   <= 1'b0;
      MTRANS        <= 1'b0;
      MWRITE        <= 1'b0;
      MSELx         <= '0;
      MADDR         <= '0;
      MWDATA        <= '0;
      bypass_req    <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      words_written <= '0;
    end else begin
      coeff_ready   <= (state_d == FETCH);
      MTRANS        <= (state_d == WRITE);
      MWRITE        <= (state_d == WRITE);
      MSELx         <= (state_d == WRITE) ? sel_d : '0;
      MADDR         <= addr_d;
      MWDATA        <= wdata_d;
      bypass_req    <= (state_d != IDLE) ? sel_d : '0;
      busy          <= (state_d != IDLE);
      done          <= (state_d == DONE);
      aborted       <= aborted_d;
      words_written <= ww_d;
    end
  end

endmodule

// File: tb/tb_dfe_coeff_loader.sv
module tb_dfe_coeff_loader;
  localparam int AW = 7;
  localparam int CW = 20;
  localparam int COMP = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [1:0]      target;
  logic            abort;
  logic            coeff_valid;
  logic [CW-1:0]   coeff_data;
  logic            coeff_ready;
  logic            MTRANS;
  logic            MWRITE;
  logic [COMP-1:0] MSELx;
  logic [AW-1:0]   MADDR;
  logic [CW-1:0]   MWDATA;
  logic [COMP-1:0] bypass_req;
  logic            busy;
  logic            done;
  logic            aborted;
  logic [6:0]      words_written;

  dfe_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target), .abort(abort),
    .coeff_valid(coeff_valid), .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .MTRANS(MTRANS), .MWRITE(MWRITE), .MSELx(MSELx), .MADDR(MADDR), .MWDATA(MWDATA),
    .bypass_req(bypass_req), .busy(busy), .done(done), .aborted(aborted),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: the expected write sequence is simply words[0..n_exp-1]
  // at addresses 0..n_exp-1, all on the one-hot select of the load's target
  logic [CW-1:0]   words [0:127];
  int              wr_cyc [0:127];
  int              n_exp, acc_n, wr_n, done_n, abort_n, cyc, done_cyc;
  logic [COMP-1:0] exp_sel;
  bit              gaps, valid_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit hs;
    hs = coeff_valid && coeff_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (hs) acc_n++;
    if (MTRANS === 1'b1) begin
      chk("write_in_range", 32'(wr_n < n_exp), 1);
      if (wr_n < n_exp) begin
        chk("wr_addr", 32'(MADDR), wr_n);
        chk("wr_data", 32'(MWDATA), 32'(words[wr_n]));
        chk("wr_sel", 32'(MSELx), 32'(exp_sel));
        chk("wr_mwrite", 32'(MWRITE), 1);
        wr_cyc[wr_n] = cyc;
      end
      wr_n++;
    end
    if (done === 1'b1) begin
      done_n++;
      done_cyc = cyc;
    end
    if (aborted === 1'b1) abort_n++;
    coeff_data  = (acc_n < n_exp) ? words[acc_n] : CW'($urandom);
    coeff_valid = gaps ? ($urandom_range(0, 2) != 0) : valid_hold;
  endtask

  task automatic begin_load(input logic [1:0] t, input int n, input bit g, input bit vh);
    n_exp = n; acc_n = 0; wr_n = 0; done_n = 0; abort_n = 0; done_cyc = -1;
    gaps = g; valid_hold = vh;
    exp_sel = COMP'(1) << t;
    target = t;
    start = 1'b1;
    coeff_valid = 1'b0;
    coeff_data = words[0];
    @(posedge clk);
    #1;
    cyc = 1;
    start = 1'b0;
    coeff_valid = g ? ($urandom_range(0, 2) != 0) : vh;
  endtask

  task automatic finish_load(input string tag, input int budget);
    int k;
    k = 0;
    while (done_n == 0 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_done_seen"}, done_n, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; target = '0; abort = 1'b0;
    coeff_valid = 1'b0; coeff_data = '0;
    n_exp = 0; acc_n = 0; wr_n = 0; done_n = 0; abort_n = 0; cyc = 0; done_cyc = -1;
    exp_sel = '0; gaps = 0; valid_hold = 0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mtrans", 32'(MTRANS), 0);
    chk("rst_msel", 32'(MSELx), 0);
    chk("rst_maddr", 32'(MADDR), 0);
    chk("rst_mwdata", 32'(MWDATA), 0);
    chk("rst_bypass", 32'(bypass_req), 0);
    chk("rst_ready", 32'(coeff_ready), 0);
    chk("rst_ww", 32'(words_written), 0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 32'(busy), 0);

    // IIR load, target 1, back-to-back words
    for (int i = 0; i < 5; i++) words[i] = CW'(20'h10 + i);
    begin_load(2'd1, 5, 1'b0, 1'b1);
    chk("iir_c1_busy", 32'(busy), 1);
    chk("iir_c1_ready", 32'(coeff_ready), 1);
    chk("iir_c1_bypass", 32'(bypass_req), 32'h2);
    finish_load("iir", 40);
    chk("iir_done_cycle", done_cyc, 11);
    chk("iir_busy_at_done", 32'(busy), 1);
    chk("iir_writes", wr_n, 5);
    for (int i = 0; i < 5; i++) chk("iir_write_cycle", wr_cyc[i], 2 + 2 * i);
    chk("iir_ww", 32'(words_written), 5);
    valid_hold = 0; coeff_valid = 1'b0;
    step();
    chk("iir_c12_busy", 32'(busy), 0);
    chk("iir_c12_done", 32'(done), 0);
    chk("iir_c12_bypass", 32'(bypass_req), 0);

    // backpressure, then a start pulse mid-load that must be ignored
    for (int i = 0; i < 5; i++) words[i] = CW'($urandom);
    begin_load(2'd3, 5, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        start = 1'b1;
        target = 2'd2;
      end
      step();
      start = 1'b0;
      chk("bp_no_mtrans", 32'(MTRANS), 0);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_ready", 32'(coeff_ready), 1);
    end
    chk("bp_bypass", 32'(bypass_req), 32'h8);
    valid_hold = 1; coeff_valid = 1'b1;
    finish_load("bp", 40);
    chk("bp_writes", wr_n, 5);
    chk("bp_ww", 32'(words_written), 5);
    valid_hold = 0; coeff_valid = 1'b0;
    step();
    step();

    // fractional decimator, 72 words with random gaps
    for (int i = 0; i < 72; i++) words[i] = CW'($urandom);
    words[5] = 20'hFFFFF;
    words[10] = 20'h80000;
    words[20] = 20'h7FFFF;
    words[71] = 20'hFFFFE;
    begin_load(2'd0, 72, 1'b1, 1'b0);
    begin
      int k;
      k = 0;
      while (done_n == 0 && k < 1000) begin
        chk("frac_bypass", 32'(bypass_req), 32'h1);
        step();
        k++;
      end
    end
    chk("frac_done_seen", done_n, 1);
    chk("frac_bypass_at_done", 32'(bypass_req), 32'h1);
    chk("frac_writes", wr_n, 72);
    chk("frac_ww", 32'(words_written), 72);
    gaps = 0; valid_hold = 0; coeff_valid = 1'b0;
    step();
    chk("frac_after_bypass", 32'(bypass_req), 0);
    step();

    // abort during the third write of a target 3 load
    for (int i = 0; i < 5; i++) words[i] = CW'(20'h500 + i);
    begin_load(2'd3, 5, 1'b0, 1'b1);
    begin
      int k;
      k = 0;
      while (wr_n < 3 && k < 40) begin
        step();
        k++;
      end
    end
    chk("ab_third_write", wr_n, 3);
    chk("ab_in_write", 32'(MTRANS), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_pulse", 32'(aborted), 1);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_mtrans", 32'(MTRANS), 0);
    chk("ab_bypass", 32'(bypass_req), 0);
    chk("ab_ww", 32'(words_written), 3);
    valid_hold = 0; coeff_valid = 1'b0;
    repeat (5) step();
    chk("ab_no_more_writes", wr_n, 3);
    chk("ab_no_done", done_n, 0);
    chk("ab_single_pulse", abort_n, 1);
    chk("ab_ww_kept", 32'(words_written), 3);

    // abort in IDLE does nothing; start+abort together in IDLE starts a load
    abort = 1'b1;
    step();
    chk("idle_abort_pulse", 32'(aborted), 0);
    chk("idle_abort_busy", 32'(busy), 0);
    for (int i = 0; i < 5; i++) words[i] = CW'($urandom);
    begin_load(2'd2, 5, 1'b0, 1'b1);
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 1);
    chk("start_abort_no_pulse", 32'(aborted), 0);
    chk("start_abort_bypass", 32'(bypass_req), 32'h4);

    // reset asserted in the middle of a write cycle
    begin
      int k;
      k = 0;
      while (MTRANS !== 1'b1 && k < 20) begin
        step();
        k++;
      end
    end
    chk("rstw_in_write", 32'(MTRANS), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstw_mtrans", 32'(MTRANS), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_bypass", 32'(bypass_req), 0);
    chk("rstw_ready", 32'(coeff_ready), 0);
    chk("rstw_ww", 32'(words_written), 0);
    valid_hold = 0; coeff_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_exp = 0;
    step();
    step();
    chk("rstw_idle_busy", 32'(busy), 0);
    chk("rstw_idle_ready", 32'(coeff_ready), 0);
    chk("rstw_idle_mtrans", 32'(MTRANS), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dfe_coeff_loader.md
# dfe_coeff_loader

Coefficient-load sequencer for the DFE filter array. It accepts a load command naming one filter target, pulls that target's coefficient words from a valid/ready stream, and issues one bus write per word on the configuration bus (MTRANS/MWRITE/MSELx/MADDR/MWDATA) at incrementing addresses. It holds the target's bypass request for the whole load. It sits between the host/boot logic and the configuration-bus master port of the filter-array top.

## Interface
- ADDR_WIDTH, 7, configuration-bus address width
- COEFF_WIDTH, 20, coefficient word width (signed)
- COMP, 4, number of bus select lines (one-hot, one per target)
- N_TAP, 72, word count for target 0 (fractional decimator)
- NUM_DENUM, 5, word count for targets 1–3 (IIR notch filters)
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  load request, sampled only in IDLE
- target  in  2  0 = frac decimator, 1 = IIR 2.4 MHz, 2 = IIR 1 MHz, 3 = IIR 2 MHz
- abort  in  1  terminate the current load
- coeff_valid  in  1  stream word valid
- coeff_data  in  COEFF_WIDTH  stream word, signed
- coeff_ready  out  1  stream ready
- MTRANS  out  1  bus transfer strobe
- MWRITE  out  1  bus write enable
- MSELx  out  COMP  one-hot target select
- MADDR  out  ADDR_WIDTH  coefficient index
- MWDATA  out  COEFF_WIDTH  coefficient word
- bypass_req  out  COMP  one-hot; holds the loaded target bypassed
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the load completes
- aborted  out  1  one-cycle pulse when a load is aborted
- words_written  out  7  writes issued in the current/last load

## Operation
- States: IDLE, FETCH, WRITE, DONE. All outputs are registered.
- Reset: state IDLE. All outputs 0, including MSELx, MADDR, MWDATA and words_written.
- IDLE:
  - On start: latch target, load last = N_TAP-1 (target 0) or NUM_DENUM-1, clear the index and words_written, then go to FETCH.
  - start while not in IDLE is ignored.
- FETCH: coeff_ready=1. On coeff_valid&coeff_ready, register coeff_data into MWDATA and the index into MADDR, then go to WRITE. With no valid word, remain in FETCH indefinitely.
- WRITE:
  - For exactly one cycle: MTRANS=1, MWRITE=1, MSELx=1<<target.
  - words_written increments at the end of the cycle.
  - If index==last, go to DONE; else increment the index and return to FETCH.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in FETCH, WRITE and DONE. bypass_req=1<<target for the same span; otherwise 0.
- Outside WRITE, MTRANS=0, MWRITE=0 and MSELx=0. MADDR and MWDATA hold their last values.
- abort:
  - In FETCH/WRITE/DONE it has priority over all other events and goes to IDLE on the next edge, with aborted=1 for one cycle.
  - No bus transfer occurs in that next cycle, and done does not pulse. words_written keeps its value.
  - In IDLE, abort has no effect. Simultaneous start+abort in IDLE: start is accepted.
- Arithmetic: MADDR is the zero-extended index, 0..last, and never wraps. words_written saturates at 127 (unreachable for the default parameters).
- Reset mid-load: immediate return to reset values. No partial bus cycle is extended.

## Timing
- Edge 0 samples start in IDLE. From cycle 1: busy=1, bypass_req set, coeff_ready=1.
- A word accepted in cycle k is written in cycle k+1 (MTRANS=1). FETCH resumes at k+2.
- Peak throughput: one write per 2 cycles.
- With valid held high, a NUM_DENUM=5 load runs as follows:
  - accepts in cycles 1,3,5,7,9
  - writes in cycles 2,4,6,8,10
  - done=1 and busy=1 in cycle 11; busy=0 in cycle 12
- An N_TAP=72 load with valid held high completes with done in cycle 145.
- Earliest next start is sampled at the edge ending cycle 12 (5-word case).

## Test plan
- Reset check: assert rst_n=0 mid-WRITE -> MTRANS, busy, bypass_req and coeff_ready are 0 immediately; state is IDLE after release.
- IIR load: target=1 with 5 words 0x00010..0x00014 streamed back-to-back -> MSELx=4'b0010 and MADDR 0..4 with matching MWDATA in cycles 2,4,6,8,10; done in cycle 11; words_written=5.
- Frac decimator load: target=0, 72 words with random gaps on coeff_valid -> exactly 72 writes with MADDR 0..71 in order and data preserved, including negative values such as 20'hFFFFF; bypass_req=4'b0001 throughout; words_written=72.
- Backpressure: hold coeff_valid low 10 cycles in FETCH -> no MTRANS; state stays FETCH; busy=1.
- Abort: assert abort during the 3rd WRITE of a target=3 load -> aborted pulse; no further MTRANS; no done; words_written=3; busy=0 the next cycle.
- Start in a busy state: pulse start with target=2 mid-load -> ignored; MSELx stays on the original target.
